// File: rtl/au_pkg.sv
// Shared audio-path types: default sample width, the packed sample record
// and the I2S receiver capture states.
package au_pkg;
    localparam int unsigned AuDataWidth = 16;

    typedef struct packed {
        logic                   right;
        logic [AuDataWidth-1:0] data;
    } au_sample_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SYNC,
        RX_SHIFT,
        RX_SKIP
    } rx_state_e;
endpackage

// File: rtl/user_au_i2s_rx_fifo.sv
// Registered-head sample FIFO with synchronous flush; push is ignored when full
// and pop is ignored when empty, so the wrapper owns the drop policy.
module user_au_i2s_rx_fifo #(
    parameter int unsigned DataWidth = 17,
    parameter int unsigned Depth     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [DataWidth-1:0]       data_i,
    input  logic                       pop_i,
    output logic [DataWidth-1:0]       data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(Depth):0]     level_o
);
    localparam int unsigned AddrW  = $clog2(Depth);
    localparam int unsigned LevelW = AddrW + 1;

    logic [DataWidth-1:0] mem [Depth];
    logic [AddrW-1:0]     wr_ptr, rd_ptr;
    logic [LevelW-1:0]    count;
    logic                 push_ok, pop_ok;

    assign empty_o = (count == '0);
    assign full_o  = (count == LevelW'(Depth));
    assign level_o = count;
    assign data_o  = mem[rd_ptr];
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AddrW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AddrW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LevelW'(1);
                2'b01:   count <= count - LevelW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= data_i;
    end
endmodule

// File: rtl/user_au_i2s_rx.sv
// I2S slave receiver: synchronizes SCK/WS/SD, deserializes MSB-first words per
// channel slot and queues {right, data} in a small FIFO with sticky error flags.
module user_au_i2s_rx
    import au_pkg::*;
#(
    parameter int unsigned DataWidth  = AuDataWidth,
    parameter int unsigned FifoDepth  = 4,
    parameter int unsigned SyncStages = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic                         clr_i,
    input  logic                         i2s_sck_i,
    input  logic                         i2s_ws_i,
    input  logic                         i2s_sd_i,
    output logic [DataWidth-1:0]         sample_o,
    output logic                         right_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(FifoDepth):0]   fifo_level_o,
    output logic                         overflow_o,
    output logic                         frame_err_o
);
    localparam int unsigned CntW    = $clog2(DataWidth + 1);
    localparam int unsigned SampleW = DataWidth + 1;

    logic [SyncStages-1:0] sck_sync, ws_sync, sd_sync;
    logic                  sck_q, sck_s, ws_s, sd_s, strobe, ws_edge;
    logic                  ws_prev, ws_seen;
    rx_state_e             state, state_d;
    logic [CntW-1:0]       cnt, cnt_d;
    logic                  ch, ch_d;
    logic [DataWidth-1:0]  shreg, shreg_d;
    logic                  push_d, push_q, err_set;
    logic [SampleW-1:0]    push_data, head;
    logic                  fifo_empty, fifo_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_q    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SyncStages-2:0], i2s_sck_i};
            ws_sync  <= {ws_sync[SyncStages-2:0], i2s_ws_i};
            sd_sync  <= {sd_sync[SyncStages-2:0], i2s_sd_i};
            sck_q    <= sck_sync[SyncStages-1];
        end
    end

    assign sck_s  = sck_sync[SyncStages-1];
    assign ws_s   = ws_sync[SyncStages-1];
    assign sd_s   = sd_sync[SyncStages-1];
    assign strobe = sck_s & ~sck_q;
    // A WS change only counts once a previous strobe has established the level.
    assign ws_edge = strobe & ws_seen & (ws_s != ws_prev);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ch_d    = ch;
        shreg_d = shreg;
        push_d  = 1'b0;
        err_set = 1'b0;
        case (state)
            RX_IDLE: if (en_i) state_d = RX_SYNC;
            RX_SYNC, RX_SKIP: begin
                if (ws_edge) begin
                    state_d = RX_SHIFT;
                    ch_d    = ws_s;
                    cnt_d   = '0;
                end
            end
            RX_SHIFT: begin
                if (strobe) begin
                    shreg_d = {shreg[DataWidth-2:0], sd_s};
                    cnt_d   = cnt + CntW'(1);
                    if (cnt == CntW'(DataWidth - 1)) begin
                        push_d  = 1'b1;
                        state_d = RX_SKIP;
                        if (ws_edge) begin
                            state_d = RX_SHIFT;
                            ch_d    = ws_s;
                            cnt_d   = '0;
                        end
                    end else if (ws_edge) begin
                        err_set = 1'b1;
                        ch_d    = ws_s;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
        if (!en_i) begin
            state_d = RX_IDLE;
            push_d  = 1'b0;
            err_set = 1'b0;
        end
        if (clr_i) begin
            state_d = en_i ? RX_SYNC : RX_IDLE;
            cnt_d   = '0;
            push_d  = 1'b0;
            err_set = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= RX_IDLE;
            cnt         <= '0;
            ch          <= 1'b0;
            ws_prev     <= 1'b0;
            ws_seen     <= 1'b0;
            push_q      <= 1'b0;
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            ch     <= ch_d;
            push_q <= push_d;
            if (clr_i) begin
                ws_seen     <= 1'b0;
                overflow_o  <= 1'b0;
                frame_err_o <= 1'b0;
            end else begin
                if (strobe) begin
                    ws_prev <= ws_s;
                    ws_seen <= 1'b1;
                end
                if (push_q && fifo_full) overflow_o  <= 1'b1;
                if (err_set)             frame_err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        shreg <= shreg_d;
        if (push_d) push_data <= {ch, shreg_d};
    end

    user_au_i2s_rx_fifo #(
        .DataWidth (SampleW),
        .Depth     (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clr_i),
        .push_i  (push_q),
        .data_i  (push_data),
        .pop_i   (ready_i),
        .data_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level_o)
    );

    assign valid_o  = ~fifo_empty;
    assign sample_o = fifo_empty ? '0 : head[DataWidth-1:0];
    assign right_o  = ~fifo_empty & head[DataWidth];
endmodule

// File: tb/tb_user_au_i2s_rx.sv
// Directed bench for user_au_i2s_rx: drives I2S slots (SCK = clk/8, 32-bit slots)
// and compares delivered beats and flags against hand-computed values.
module tb_user_au_i2s_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        sck = 1'b0;
    logic        ws = 1'b0;
    logic        sd = 1'b0;
    logic [15:0] sample;
    logic        right;
    logic        valid;
    logic        ready = 1'b0;
    logic [2:0]  level;
    logic        overflow;
    logic        frame_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] beats[$];

    user_au_i2s_rx #(
        .DataWidth  (16),
        .FifoDepth  (4),
        .SyncStages (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .clr_i        (clr),
        .i2s_sck_i    (sck),
        .i2s_ws_i     (ws),
        .i2s_sd_i     (sd),
        .sample_o     (sample),
        .right_o      (right),
        .valid_o      (valid),
        .ready_i      (ready),
        .fifo_level_o (level),
        .overflow_o   (overflow),
        .frame_err_o  (frame_err)
    );

    always #5 clk = ~clk;

    // Beats accepted on a clock edge are visible on the preceding falling edge.
    always @(negedge clk) begin
        if (rst_n && valid && ready) beats.push_back({right, sample});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bits first..last of an nbits slot; WS moves to next_ch on the final bit.
    task automatic send_bits(input logic ch, input logic [15:0] data, input int first,
                             input int last, input int nbits, input logic next_ch);
        for (int i = first; i <= last; i++) begin
            sck = 1'b0;
            ws  = (i == nbits - 1) ? next_ch : ch;
            sd  = (i < 16) ? data[15 - i] : 1'b0;
            tick(4);
            sck = 1'b1;
            tick(4);
        end
    endtask

    task automatic send_slot(input logic ch, input logic [15:0] data, input logic next_ch);
        send_bits(ch, data, 0, 31, 32, next_ch);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
    endtask

    task automatic check_beats(input string tag, input logic [16:0] exp[$]);
        check({tag, "_count"}, beats.size(), exp.size());
        for (int i = 0; i < exp.size() && i < beats.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), {15'd0, beats[i]}, {15'd0, exp[i]});
    endtask

    initial begin
        logic [16:0] exp[$];

        tick(3);
        @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_level", level, 0);
        check("rst_sample", sample, 0);
        check("rst_right", right, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // Plain stereo frame, consumer always ready.
        en = 1'b1;
        ready = 1'b1;
        tick(2);
        send_slot(1'b1, 16'h0000, 1'b0);
        send_slot(1'b0, 16'hA5A5, 1'b1);
        send_slot(1'b1, 16'h5A5A, 1'b0);
        tick(20);
        exp = '{{1'b0, 16'hA5A5}, {1'b1, 16'h5A5A}};
        check_beats("stereo", exp);
        check("stereo_overflow", overflow, 0);
        check("stereo_frame_err", frame_err, 0);

        // Enable arrives part-way through a left slot.
        en = 1'b0;
        pulse_clr();
        beats.delete();
        send_slot(1'b1, 16'h0000, 1'b0);
        send_bits(1'b0, 16'hC3C3, 0, 9, 32, 1'b1);
        en = 1'b1;
        send_bits(1'b0, 16'hC3C3, 10, 31, 32, 1'b1);
        send_slot(1'b1, 16'h3C3C, 1'b0);
        tick(20);
        exp = '{{1'b1, 16'h3C3C}};
        check_beats("late_en", exp);
        check("late_en_level", level, 0);

        // Stalled consumer for three frames: overflow keeps the oldest four.
        pulse_clr();
        beats.delete();
        ready = 1'b0;
        send_slot(1'b1, 16'h0000, 1'b0);
        send_slot(1'b0, 16'h1111, 1'b1);
        send_slot(1'b1, 16'h2222, 1'b0);
        send_slot(1'b0, 16'h3333, 1'b1);
        send_slot(1'b1, 16'h4444, 1'b0);
        send_slot(1'b0, 16'h5555, 1'b1);
        send_slot(1'b1, 16'h6666, 1'b0);
        tick(20);
        check("stall_level", level, 4);
        check("stall_overflow", overflow, 1);
        check("stall_frame_err", frame_err, 0);
        check("stall_head", {right, sample}, {1'b0, 16'h1111});
        ready = 1'b1;
        tick(10);
        exp = '{{1'b0, 16'h1111}, {1'b1, 16'h2222}, {1'b0, 16'h3333}, {1'b1, 16'h4444}};
        check_beats("stall", exp);
        check("stall_drained", level, 0);

        // Short left slot: WS toggles after 10 bits.
        pulse_clr();
        beats.delete();
        send_slot(1'b1, 16'h0000, 1'b0);
        send_bits(1'b0, 16'hFFFF, 0, 10, 11, 1'b1);
        send_slot(1'b1, 16'h1234, 1'b0);
        tick(20);
        check("short_frame_err", frame_err, 1);
        check("short_overflow", overflow, 0);
        exp = '{{1'b1, 16'h1234}};
        check_beats("short", exp);

        // Build level 3 with both flags set, then clear.
        beats.delete();
        ready = 1'b0;
        send_slot(1'b0, 16'h0101, 1'b1);
        send_slot(1'b1, 16'h0202, 1'b0);
        send_slot(1'b0, 16'h0303, 1'b1);
        send_slot(1'b1, 16'h0404, 1'b0);
        send_slot(1'b0, 16'h0505, 1'b1);
        send_slot(1'b1, 16'h0606, 1'b0);
        tick(20);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(2);
        exp = '{{1'b0, 16'h0101}};
        check_beats("pre_clr", exp);
        check("pre_clr_level", level, 3);
        check("pre_clr_overflow", overflow, 1);
        check("pre_clr_frame_err", frame_err, 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        @(negedge clk);
        check("clr_level", level, 0);
        check("clr_valid", valid, 0);
        check("clr_overflow", overflow, 0);
        check("clr_frame_err", frame_err, 0);
        tick(1);

        // Asynchronous reset in the middle of a right slot.
        beats.delete();
        send_slot(1'b1, 16'h0000, 1'b0);
        send_slot(1'b0, 16'hCAFE, 1'b1);
        send_bits(1'b1, 16'hBEEF, 0, 9, 32, 1'b0);
        check("pre_rst_level", level, 1);
        rst_n = 1'b0;
        tick(3);
        @(negedge clk);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_sample", sample, 0);
        tick(1);
        rst_n = 1'b1;
        beats.delete();
        ready = 1'b1;
        tick(2);
        send_bits(1'b1, 16'hBEEF, 10, 31, 32, 1'b0);
        send_slot(1'b0, 16'h7E81, 1'b1);
        send_slot(1'b1, 16'h0F0F, 1'b0);
        tick(20);
        exp = '{{1'b0, 16'h7E81}, {1'b1, 16'h0F0F}};
        check_beats("post_rst", exp);
        check("post_rst_overflow", overflow, 0);
        check("post_rst_frame_err", frame_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
